// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared encodings for the execute-stage ALU sequencer
package ex_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    localparam logic [2:0] CF_ALWAYS = 3'd0;
    localparam logic [2:0] CF_LE     = 3'd1;
    localparam logic [2:0] CF_L      = 3'd2;
    localparam logic [2:0] CF_E      = 3'd3;
    localparam logic [2:0] CF_NE     = 3'd4;
    localparam logic [2:0] CF_GE     = 3'd5;
    localparam logic [2:0] CF_G      = 3'd6;
    localparam logic [2:0] CF_NEVER  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ALU  = 2'd1,
        ST_MUL  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;

    localparam logic [2:0] CC_RESET = 3'b001;

    // Encodings above MUL have no datapath behind them.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/alu_core_64.sv
// rtl/alu_core_64.sv - combinational add/sub/and/xor core with {OF,SF,ZF}
module alu_core_64
    import ex_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [2:0]   i_op,
    output logic [W-1:0] o_y,
    output logic [2:0]   o_flags
);

    logic         w_sub;
    logic [W-1:0] w_b_eff;
    logic [W-1:0] w_sum;

    // SUB reuses the adder as a + ~b + 1; overflow test then reads the same for both.
    assign w_sub   = (i_op == OP_SUB);
    assign w_b_eff = w_sub ? ~i_b : i_b;
    assign w_sum   = i_a + w_b_eff + W'(w_sub);

    // Result select and flag generation; MUL and illegal codes give zero.
    always_comb begin
        o_y     = '0;
        o_flags = '0;
        case (i_op)
            OP_ADD, OP_SUB: begin
                o_y            = w_sum;
                o_flags[CC_OF] = (i_a[W-1] == w_b_eff[W-1]) && (w_sum[W-1] != i_a[W-1]);
            end
            OP_AND:  o_y = i_a & i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            default: o_y = '0;
        endcase
        o_flags[CC_SF] = o_y[W-1];
        o_flags[CC_ZF] = (o_y == '0);
    end

endmodule

// File: rtl/ex_alu_sequencer.sv
// rtl/ex_alu_sequencer.sv - multi-cycle execute controller with shift-add multiply and CC
module ex_alu_sequencer
    import ex_pkg::*;
#(
    parameter int W         = 64,
    parameter int MUL_STEPS = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         set_cc,
    input  logic [2:0]   cond_fn,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [2:0]   cc,
    output logic         cnd,
    output logic         err
);

    localparam int CW = $clog2(MUL_STEPS + 1);

    state_t       r_state;
    state_t       w_state_next;

    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [2:0]   r_op;
    logic         r_set_cc;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_mcand;
    logic [W-1:0] r_mplier;
    logic [CW-1:0] r_cnt;
    logic [W-1:0] r_result;
    logic [2:0]   r_cc;

    logic         w_in_mul;
    logic [W-1:0] w_alu_a;
    logic [W-1:0] w_alu_b;
    logic [2:0]   w_alu_op;
    logic [W-1:0] w_alu_y;
    logic [2:0]   w_alu_flags;
    logic         w_mul_last;
    logic [W-1:0] w_acc_next;
    logic [2:0]   w_mul_flags;
    logic         w_lt;

    // During MUL the shared adder accumulates acc + multiplicand.
    assign w_in_mul = (r_state == ST_MUL);
    assign w_alu_a  = w_in_mul ? r_acc   : r_a;
    assign w_alu_b  = w_in_mul ? r_mcand : r_b;
    assign w_alu_op = w_in_mul ? OP_ADD  : r_op;

    alu_core_64 #(.W(W)) u_alu (
        .i_a     (w_alu_a),
        .i_b     (w_alu_b),
        .i_op    (w_alu_op),
        .o_y     (w_alu_y),
        .o_flags (w_alu_flags)
    );

    assign w_mul_last  = (r_cnt == CW'(MUL_STEPS - 1));
    assign w_acc_next  = r_mplier[0] ? w_alu_y : r_acc;
    assign w_mul_flags = {1'b0, w_acc_next[W-1], (w_acc_next == '0)};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (op == OP_MUL) ? ST_MUL : ST_ALU;
                end
            end
            ST_ALU: begin
                busy         = 1'b1;
                w_state_next = ST_FIN;
            end
            ST_MUL: begin
                busy = 1'b1;
                if (w_mul_last) begin
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                done         = 1'b1;
                err          = !op_is_legal(r_op);
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand latch, multiply iteration, result and condition-code writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_set_cc <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cc     <= CC_RESET;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_op     <= op;
                        r_set_cc <= set_cc;
                        r_acc    <= '0;
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_cnt    <= '0;
                    end
                end
                ST_ALU: begin
                    r_result <= w_alu_y;
                    if (r_set_cc && op_is_legal(r_op)) begin
                        r_cc <= w_alu_flags;
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_result <= w_acc_next;
                        if (r_set_cc) begin
                            r_cc <= w_mul_flags;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_lt = r_cc[CC_SF] ^ r_cc[CC_OF];

    // Branch/cmov condition from the live CC register.
    always_comb begin
        cnd = 1'b0;
        case (cond_fn)
            CF_ALWAYS: cnd = 1'b1;
            CF_LE:     cnd = w_lt | r_cc[CC_ZF];
            CF_L:      cnd = w_lt;
            CF_E:      cnd = r_cc[CC_ZF];
            CF_NE:     cnd = ~r_cc[CC_ZF];
            CF_GE:     cnd = ~w_lt;
            CF_G:      cnd = ~w_lt & ~r_cc[CC_ZF];
            CF_NEVER:  cnd = 1'b0;
        endcase
    end

    assign result = r_result;
    assign cc     = r_cc;

endmodule

// File: tb/tb_ex_alu_sequencer.sv
// tb/tb_ex_alu_sequencer.sv - scoreboard bench with random ops against an arithmetic model
module tb_ex_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic [2:0]  cond_fn;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [2:0]  cc;
    logic        cnd;
    logic        err;

    int n_tests = 0;
    int n_fails = 0;

    typedef struct packed {
        logic [63:0] r;
        logic [2:0]  cc;
        logic        e;
    } exp_t;

    exp_t       sbq[$];
    logic [2:0] model_cc;

    ex_alu_sequencer #(.W(64), .MUL_STEPS(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .set_cc  (set_cc),
        .cond_fn (cond_fn),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cc      (cc),
        .cnd     (cnd),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: true signed arithmetic; overflow when the exact value does not fit in 64 bits.
    function automatic exp_t model(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                                   input logic sc);
        exp_t              e;
        logic signed [64:0] sx, sy, exact;
        logic              of;
        sx = {x[63], x};
        sy = {y[63], y};
        of = 1'b0;
        e.e = 1'b0;
        case (o)
            3'd0: begin exact = sx + sy; e.r = exact[63:0]; of = (exact != {e.r[63], e.r}); end
            3'd1: begin exact = sx - sy; e.r = exact[63:0]; of = (exact != {e.r[63], e.r}); end
            3'd2: e.r = x & y;
            3'd3: e.r = x ^ y;
            3'd4: e.r = x * y;
            default: begin e.r = 64'd0; e.e = 1'b1; end
        endcase
        if (sc && !e.e) begin
            model_cc = {of, e.r[63], (e.r == 64'd0)};
        end
        e.cc = model_cc;
        return e;
    endfunction

    function automatic logic model_cnd(input logic [2:0] c, input logic [2:0] cf);
        logic zf, sf, of, lt;
        zf = c[0];
        sf = c[1];
        of = c[2];
        lt = (sf != of);
        case (cf)
            3'd0: return 1'b1;
            3'd1: return lt || zf;
            3'd2: return lt;
            3'd3: return zf;
            3'd4: return !zf;
            3'd5: return !lt;
            3'd6: return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", result, e.r);
                chk("cc", {61'd0, cc}, {61'd0, e.cc});
                chk("err", {63'd0, err}, {63'd0, e.e});
            end
        end else if (!rst && err) begin
            chk("err_without_done", 64'd1, 64'd0);
        end
    end

    task automatic sweep_cnd();
        for (int cf = 0; cf < 8; cf++) begin
            cond_fn = 3'(cf);
            #1;
            chk($sformatf("cnd_fn%0d", cf), {63'd0, cnd}, {63'd0, model_cnd(model_cc, 3'(cf))});
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic sc, input bit poke);
        exp_t e;
        int   n;
        int   busy_cnt;
        int   lat_exp;
        e = model(o, x, y, sc);
        lat_exp = (o == 3'd4) ? 65 : 2;
        @(negedge clk);
        op = o; a = x; b = y; set_cc = sc; start = 1'b1;
        sbq.push_back(e);
        @(posedge clk);
        n = 1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        op = 3'($urandom_range(0, 7));
        set_cc = ~sc;
        while (!done && n < 200) begin
            if (busy) busy_cnt++;
            start = (poke && n == 10);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("latency", 64'(n), 64'(lat_exp));
        chk("busy_cycles", 64'(busy_cnt), 64'(lat_exp - 1));
        chk("busy_low_at_done", {63'd0, busy}, 64'd0);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_single", {63'd0, done}, 64'd0);
        sweep_cnd();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 64'd0; b = 64'd0; set_cc = 1'b0; cond_fn = 3'd0;
        model_cc = 3'b001;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_cc", {61'd0, cc}, 64'd1);
        chk("rst_cnd_always", {63'd0, cnd}, 64'd1);
        @(negedge clk);
        rst = 1'b0;

        do_op(3'd1, 64'd5, 64'd7, 1'b1, 1'b0);
        do_op(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0);
        do_op(3'd4, -64'sd3, 64'd7, 1'b1, 1'b1);
        do_op(3'd3, 64'h1234, 64'h1234, 1'b0, 1'b0);
        do_op(3'd3, 64'h1234, 64'h1234, 1'b1, 1'b0);

        // Abort a multiply partway through with an asynchronous reset.
        @(negedge clk);
        op = 3'd4; a = -64'sd3; b = 64'd7; set_cc = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_cc", {61'd0, cc}, 64'd1);
        model_cc = 3'b001;
        @(negedge clk);
        rst = 1'b0;
        do_op(3'd0, 64'd2, 64'd2, 1'b1, 1'b0);

        do_op(3'd6, 64'd9, 64'd9, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [63:0] x, y;
            logic [2:0]  o;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: x = 64'h7FFF_FFFF_FFFF_FFFF;
                1: y = 64'h8000_0000_0000_0000;
                2: y = x;
                default: ;
            endcase
            o = 3'($urandom_range(0, 7));
            do_op(o, x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
